// File: rtl/lsu_ctrl.sv
// Load/store unit controller: word-aligned access to a single-port dmem, sub-word
// stores by read-modify-write. Optional macro LSU_MISALIGN_TRAP_EN traps misaligned access.
module lsu_ctrl #(
  parameter int unsigned DMEM_DEPTH = 32,
  parameter int unsigned DMEM_AW    = 5
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  input  logic [31:0] i_ld_data
);

  localparam logic [31:0] AddrLimit = 32'(DMEM_DEPTH * 4);

  typedef enum logic [2:0] {StIdle, StRd, StWait, StWr, StResp} state_e;

  state_e state_q, state_d;

  logic [DMEM_AW-1:0] widx_q;
  logic [1:0]         boff_q;
  logic [15:0]        wdata_q;
  logic               we_q;
  logic               err_q;
  logic [2:0]         funct3_q;
  logic [31:0]        st_data_q;
  logic [31:0]        rdata_q;

  logic        accept;
  logic        legal;
  logic        req_err;
  logic [31:0] addr_al;

  // Request decode; only meaningful in the accept cycle.
  always_comb begin
    accept  = i_req_valid && (state_q == StIdle);
    legal   = 1'b0;
    if (i_req_we) begin
      case (i_req_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (i_req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        default:                                legal = 1'b0;
      endcase
    end
    addr_al = i_req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    req_err = !legal || (i_req_addr >= AddrLimit) ||
              ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
              ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    req_err = !legal || (i_req_addr >= AddrLimit);
    // Silently snap to natural alignment instead of trapping.
    if (i_req_funct3[1:0] == 2'b01) begin
      addr_al[0] = 1'b0;
    end else if (i_req_funct3[1:0] == 2'b10) begin
      addr_al[1:0] = 2'b00;
    end
`endif
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merged;

  always_comb begin
    case (boff_q)
      2'b00:   ld_byte = i_ld_data[7:0];
      2'b01:   ld_byte = i_ld_data[15:8];
      2'b10:   ld_byte = i_ld_data[23:16];
      default: ld_byte = i_ld_data[31:24];
    endcase
    ld_half = boff_q[1] ? i_ld_data[31:16] : i_ld_data[15:0];

    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = i_ld_data;
    endcase

    merged = i_ld_data;
    if (funct3_q[1:0] == 2'b00) begin
      case (boff_q)
        2'b00:   merged[7:0]   = wdata_q[7:0];
        2'b01:   merged[15:8]  = wdata_q[7:0];
        2'b10:   merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (boff_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (req_err) begin
            state_d = StResp;
          end else if (i_req_we && (i_req_funct3 == 3'b010)) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd:    state_d = StWait;
      StWait:  state_d = we_q ? StWr : StResp;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      widx_q    <= '0;
      boff_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      funct3_q  <= '0;
      st_data_q <= '0;
      rdata_q   <= '0;
    end else begin
      if (accept) begin
        widx_q    <= addr_al[DMEM_AW+1:2];
        boff_q    <= addr_al[1:0];
        wdata_q   <= i_req_wdata[15:0];
        we_q      <= i_req_we;
        err_q     <= req_err;
        funct3_q  <= i_req_funct3;
        st_data_q <= i_req_wdata;
        rdata_q   <= '0;
      end
      if (state_q == StWait) begin
        if (we_q) begin
          st_data_q <= merged;
        end else begin
          rdata_q <= ld_ext;
        end
      end
    end
  end

  logic busy;
  assign busy        = (state_q != StIdle);
  assign o_req_ready = (state_q == StIdle);
  assign o_rsp_valid = (state_q == StResp);
  assign o_rsp_err   = o_rsp_valid && err_q;
  assign o_rsp_rdata = o_rsp_valid ? rdata_q : '0;
  assign o_lsu_wren  = (state_q == StWr);
  assign o_lsu_addr  = busy ? {{(30 - DMEM_AW){1'b0}}, widx_q, 2'b00} : '0;
  assign o_st_data   = busy ? st_data_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: behavioural dmem, reference memory and an expected-response queue.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_we;
  logic [2:0]  i_req_funct3;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic [31:0] i_ld_data;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .DMEM_DEPTH(32),
    .DMEM_AW   (5)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_wdata (i_req_wdata),
    .i_req_we    (i_req_we),
    .i_req_funct3(i_req_funct3),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_lsu_addr  (o_lsu_addr),
    .o_st_data   (o_st_data),
    .o_lsu_wren  (o_lsu_wren),
    .i_ld_data   (i_ld_data)
  );

  logic [31:0] dmem    [32];
  logic [31:0] ref_mem [32];

  always @(posedge clk) begin
    if (o_lsu_wren) dmem[o_lsu_addr[6:2]] <= o_st_data;
    i_ld_data <= dmem[o_lsu_addr[6:2]];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr_n;
    logic [31:0] wr_data;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] rd, input logic er, input int lat,
                              input int wn, input logic [31:0] wd);
    exp_t e;
    e.rdata = rd; e.err = er; e.lat = lat; e.wr_n = wn; e.wr_data = wd;
    return e;
  endfunction

  // Reference behaviour of one request, applied to ref_mem.
  task automatic model(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic [2:0] f3, output exp_t e);
    logic        legal, mis;
    logic [31:0] aa, w, m;
    logic [7:0]  b;
    logic [15:0] h;
    int          sz;
    e = mk(32'd0, 1'b1, 1, 0, 32'd0);
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'd0);
    aa  = a;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) legal = 1'b0;
`else
    if (mis) aa = (sz == 2) ? {a[31:1], 1'b0} : {a[31:2], 2'b00};
`endif
    if (!legal || a >= 32'd128) return;
    w = ref_mem[aa[6:2]];
    b = 8'(w >> (8 * aa[1:0]));
    h = aa[1] ? w[31:16] : w[15:0];
    if (!we) begin
      case (f3)
        3'd0: e = mk({{24{b[7]}}, b}, 1'b0, 3, 0, 32'd0);
        3'd1: e = mk({{16{h[15]}}, h}, 1'b0, 3, 0, 32'd0);
        3'd4: e = mk({24'd0, b}, 1'b0, 3, 0, 32'd0);
        3'd5: e = mk({16'd0, h}, 1'b0, 3, 0, 32'd0);
        default: e = mk(w, 1'b0, 3, 0, 32'd0);
      endcase
    end else if (f3 == 3'd2) begin
      e = mk(32'd0, 1'b0, 2, 1, wd);
      ref_mem[aa[6:2]] = wd;
    end else begin
      m = w;
      if (sz == 1) m[8*aa[1:0] +: 8] = wd[7:0];
      else if (aa[1]) m[31:16] = wd[15:0];
      else m[15:0] = wd[15:0];
      e = mk(32'd0, 1'b0, 4, 3, m);
      ref_mem[aa[6:2]] = m;
    end
  endtask

  task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [2:0] f3, input exp_t e);
    exp_t p;
    int   n = 0;
    int   wr_seen = 0;
    int   wr_n = 0;
    logic [31:0] wr_d = '0;
    bit   got = 0;
    sb_q.push_back(e);
    @(negedge clk);
    for (int k = 0; k < 20 && !o_req_ready; k++) @(negedge clk);
    check("ready_before_req", 32'(o_req_ready), 32'd1);
    i_req_valid = 1'b1; i_req_addr = a; i_req_wdata = wd; i_req_we = we; i_req_funct3 = f3;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (n == 1) check("ready_busy", 32'(o_req_ready), 32'd0);
      if (o_lsu_wren) begin
        wr_seen++;
        wr_n = n;
        wr_d = o_st_data;
      end
      if (o_rsp_valid) begin
        got = 1;
        p = sb_q.pop_front();
        check("latency", n, p.lat);
        check("rdata", o_rsp_rdata, p.rdata);
        check("err", 32'(o_rsp_err), 32'(p.err));
        check("wr_count", wr_seen, (p.wr_n != 0) ? 1 : 0);
        if (p.wr_n != 0) begin
          check("wr_cycle", wr_n, p.wr_n);
          check("st_data", wr_d, p.wr_data);
        end
      end
    end
    if (!got) begin
      check("rsp_timeout", 32'd0, 32'd1);
      void'(sb_q.pop_front());
    end else begin
      @(negedge clk);
      check("rsp_one_cycle", 32'(o_rsp_valid), 32'd0);
      check("ready_after_rsp", 32'(o_req_ready), 32'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   wr_seen;
    int   rsp_seen;
    for (int i = 0; i < 32; i++) begin
      dmem[i]    = (i * 32'h0103_0507) ^ 32'hA5A5_0000;
      ref_mem[i] = dmem[i];
    end
    dmem[2] = 32'h8001_7FF0; ref_mem[2] = 32'h8001_7FF0;
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    i_req_we = 1'b0; i_req_funct3 = '0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    check("rst_rdata", o_rsp_rdata, 32'd0);
    check("rst_wren", 32'(o_lsu_wren), 32'd0);
    check("rst_addr", o_lsu_addr, 32'd0);
    check("rst_st_data", o_st_data, 32'd0);

    // Extension cases on word 0x08 = 0x80017FF0.
    run_req(32'h0B, 32'd0, 1'b0, 3'b000, mk(32'hFFFF_FF80, 1'b0, 3, 0, 32'd0));
    run_req(32'h0B, 32'd0, 1'b0, 3'b100, mk(32'h0000_0080, 1'b0, 3, 0, 32'd0));
    run_req(32'h08, 32'd0, 1'b0, 3'b001, mk(32'h0000_7FF0, 1'b0, 3, 0, 32'd0));
    // Sub-word store via read-modify-write.
    run_req(32'h09, 32'h0000_00AA, 1'b1, 3'b000, mk(32'd0, 1'b0, 4, 3, 32'h8001_AAF0));
    ref_mem[2] = 32'h8001_AAF0;
    run_req(32'h08, 32'd0, 1'b0, 3'b010, mk(32'h8001_AAF0, 1'b0, 3, 0, 32'd0));
    run_req(32'h10, 32'hDEAD_BEEF, 1'b1, 3'b010, mk(32'd0, 1'b0, 2, 1, 32'hDEAD_BEEF));
    ref_mem[4] = 32'hDEAD_BEEF;
    run_req(32'h10, 32'd0, 1'b0, 3'b010, mk(32'hDEAD_BEEF, 1'b0, 3, 0, 32'd0));
`ifdef LSU_MISALIGN_TRAP_EN
    run_req(32'h0A, 32'd0, 1'b0, 3'b010, mk(32'd0, 1'b1, 1, 0, 32'd0));
`else
    run_req(32'h0A, 32'd0, 1'b0, 3'b010, mk(32'h8001_AAF0, 1'b0, 3, 0, 32'd0));
`endif
    run_req(32'h80, 32'd0, 1'b0, 3'b010, mk(32'd0, 1'b1, 1, 0, 32'd0));
    run_req(32'h80, 32'h1234_5678, 1'b1, 3'b010, mk(32'd0, 1'b1, 1, 0, 32'd0));
    run_req(32'h04, 32'd0, 1'b0, 3'b011, mk(32'd0, 1'b1, 1, 0, 32'd0));

    // Reset while an SB sits in WAIT.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_addr = 32'h04; i_req_wdata = 32'h0000_0055;
    i_req_we = 1'b1; i_req_funct3 = 3'b000;
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    wr_seen = 0; rsp_seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (o_lsu_wren) wr_seen++;
    end
    i_reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (o_lsu_wren) wr_seen++;
      if (o_rsp_valid) rsp_seen++;
    end
    i_reset = 1'b0;
    @(negedge clk);
    check("ready_after_abort", 32'(o_req_ready), 32'd1);
    repeat (5) begin
      if (o_lsu_wren) wr_seen++;
      if (o_rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    check("abort_wr", wr_seen, 32'd0);
    check("abort_rsp", rsp_seen, 32'd0);
    run_req(32'h04, 32'd0, 1'b0, 3'b010, mk(ref_mem[1], 1'b0, 3, 0, 32'd0));

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, wd;
      logic        we;
      logic [2:0]  f3;
      a  = 32'($urandom_range(0, 143));
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      model(a, wd, we, f3, e);
      run_req(a, wd, we, f3, e);
    end
    for (int i = 0; i < 32; i++) begin
      run_req(32'(i * 4), 32'd0, 1'b0, 3'b010, mk(ref_mem[i], 1'b0, 3, 0, 32'd0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
